// File: rtl/target_centroid_calc.sv
// Binary-image target tracker: accumulates area, coordinate sums and bounding box per frame,
// then derives the centroid with two serial restoring dividers and publishes one result per frame.
module target_centroid_calc #(
  parameter int unsigned H_PIXEL  = 640,
  parameter int unsigned V_PIXEL  = 480,
  parameter int unsigned MIN_AREA = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  output logic        obj_valid,
  output logic        obj_found,
  output logic [9:0]  obj_x_min,
  output logic [9:0]  obj_x_max,
  output logic [9:0]  obj_y_min,
  output logic [9:0]  obj_y_max,
  output logic [9:0]  obj_cx,
  output logic [9:0]  obj_cy,
  output logic [18:0] obj_area,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StAccum, StDivide, StPublish} state_e;

  localparam logic [9:0]  XSat     = 10'(H_PIXEL - 1);
  localparam logic [9:0]  YSat     = 10'(V_PIXEL - 1);
  localparam logic [18:0] MinArea  = 19'(MIN_AREA);
  localparam logic [4:0]  LastIter = 5'd27;

  state_e state_q, state_d;
  logic vsync_q, href_q;
  logic frame_edge, line_end, pix_en, hit;
  logic snap, iterate, publish, ovr;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [18:0] area_q, area_d;
  logic [27:0] sumx_q, sumx_d, sumy_q, sumy_d;
  logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [18:0] sh_area_q;
  logic [9:0]  sh_xmin_q, sh_xmax_q, sh_ymin_q, sh_ymax_q;
  logic [18:0] remx_q, remy_q;
  logic [27:0] dvdx_q, dvdy_q;
  logic [4:0]  cnt_q;
  logic        found_w;

  // One restoring step: the dividend register shifts left and collects quotient bits at its LSB.
  function automatic logic [46:0] div_step(input logic [18:0] rem, input logic [27:0] dvd,
                                           input logic [18:0] dvs);
    logic [19:0] shl;
    logic        ge;
    logic [18:0] nrem;
    shl  = {rem, dvd[27]};
    ge   = shl >= {1'b0, dvs};
    nrem = ge ? 19'(shl - {1'b0, dvs}) : shl[18:0];
    return {nrem, dvd[26:0], ge};
  endfunction

  assign frame_edge = per_frame_vsync & ~vsync_q;
  assign line_end   = ~per_frame_href & href_q;
  assign pix_en     = per_frame_clken & per_frame_href;
  assign hit        = pix_en & per_img_bit;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (line_end) x_d = '0;
    else if (pix_en && x_q != XSat) x_d = x_q + 10'd1;
    if (frame_edge) y_d = '0;
    else if (line_end && y_q != YSat) y_d = y_q + 10'd1;
  end

  always_comb begin
    area_d = area_q;
    sumx_d = sumx_q;
    sumy_d = sumy_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (frame_edge) begin
      area_d = '0;
      sumx_d = '0;
      sumy_d = '0;
      xmin_d = 10'd1023;
      xmax_d = '0;
      ymin_d = 10'd1023;
      ymax_d = '0;
    end else if (hit) begin
      area_d = area_q + 19'd1;
      sumx_d = sumx_q + 28'(x_q);
      sumy_d = sumy_q + 28'(y_q);
      if (x_q < xmin_q) xmin_d = x_q;
      if (x_q > xmax_q) xmax_d = x_q;
      if (y_q < ymin_q) ymin_d = y_q;
      if (y_q > ymax_q) ymax_d = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      area_q  <= '0;
      sumx_q  <= '0;
      sumy_q  <= '0;
      xmin_q  <= 10'd1023;
      xmax_q  <= '0;
      ymin_q  <= 10'd1023;
      ymax_q  <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      x_q     <= x_d;
      y_q     <= y_d;
      area_q  <= area_d;
      sumx_q  <= sumx_d;
      sumy_q  <= sumy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_edge) state_d = StAccum;
      StAccum:   if (frame_edge) state_d = StDivide;
      StDivide:  if (cnt_q == LastIter) state_d = StPublish;
      StPublish: state_d = StAccum;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    snap    = (state_q == StAccum) && frame_edge;
    iterate = (state_q == StDivide);
    publish = (state_q == StPublish);
    ovr     = frame_edge && (state_q == StDivide || state_q == StPublish);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_area_q <= '0;
      sh_xmin_q <= 10'd1023;
      sh_xmax_q <= '0;
      sh_ymin_q <= 10'd1023;
      sh_ymax_q <= '0;
      remx_q    <= '0;
      remy_q    <= '0;
      dvdx_q    <= '0;
      dvdy_q    <= '0;
      cnt_q     <= '0;
    end else if (snap) begin
      sh_area_q <= area_q;
      sh_xmin_q <= xmin_q;
      sh_xmax_q <= xmax_q;
      sh_ymin_q <= ymin_q;
      sh_ymax_q <= ymax_q;
      remx_q    <= '0;
      remy_q    <= '0;
      dvdx_q    <= sumx_q;
      dvdy_q    <= sumy_q;
      cnt_q     <= '0;
    end else if (iterate) begin
      cnt_q <= cnt_q + 5'd1;
      if (sh_area_q != '0) begin
        {remx_q, dvdx_q} <= div_step(remx_q, dvdx_q, sh_area_q);
        {remy_q, dvdy_q} <= div_step(remy_q, dvdy_q, sh_area_q);
      end
    end
  end

  assign found_w = sh_area_q >= MinArea;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_valid <= 1'b0;
      overrun   <= 1'b0;
      obj_found <= 1'b0;
      obj_area  <= '0;
      obj_x_min <= '0;
      obj_x_max <= '0;
      obj_y_min <= '0;
      obj_y_max <= '0;
      obj_cx    <= '0;
      obj_cy    <= '0;
    end else begin
      obj_valid <= publish;
      overrun   <= ovr;
      if (publish) begin
        obj_found <= found_w;
        obj_area  <= sh_area_q;
        obj_x_min <= found_w ? sh_xmin_q : '0;
        obj_x_max <= found_w ? sh_xmax_q : '0;
        obj_y_min <= found_w ? sh_ymin_q : '0;
        obj_y_max <= found_w ? sh_ymax_q : '0;
        obj_cx    <= (found_w && sh_area_q != '0) ? dvdx_q[9:0] : '0;
        obj_cy    <= (found_w && sh_area_q != '0) ? dvdy_q[9:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_target_centroid_calc.sv
// Directed bench: two instances (default build, and a small 128x64 build with MIN_AREA=1)
// share one pixel stream; results are compared against hand-computed frame statistics.
module tb_target_centroid_calc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0, href = 1'b0, clken = 1'b0, pix = 1'b0;

  logic        a_valid, a_found, a_overrun, b_valid, b_found, b_overrun;
  logic [9:0]  a_xmin, a_xmax, a_ymin, a_ymax, a_cx, a_cy;
  logic [9:0]  b_xmin, b_xmax, b_ymin, b_ymax, b_cx, b_cy;
  logic [18:0] a_area, b_area;

  always #5 clk = ~clk;

  target_centroid_calc dut_a (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(pix), .obj_valid(a_valid), .obj_found(a_found),
    .obj_x_min(a_xmin), .obj_x_max(a_xmax), .obj_y_min(a_ymin), .obj_y_max(a_ymax),
    .obj_cx(a_cx), .obj_cy(a_cy), .obj_area(a_area), .overrun(a_overrun)
  );

  target_centroid_calc #(.H_PIXEL(128), .V_PIXEL(64), .MIN_AREA(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(pix), .obj_valid(b_valid), .obj_found(b_found),
    .obj_x_min(b_xmin), .obj_x_max(b_xmax), .obj_y_min(b_ymin), .obj_y_max(b_ymax),
    .obj_cx(b_cx), .obj_cy(b_cy), .obj_area(b_area), .overrun(b_overrun)
  );

  typedef struct {
    logic        found;
    logic [18:0] area;
    logic [9:0]  cx, cy, xmin, xmax, ymin, ymax;
  } res_t;

  typedef struct {
    int   kind;
    int   width;
    int   lines;
    res_t exp_a;
    res_t exp_b;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic res_t mk(input logic f, input int area, input int cx, input int cy,
                              input int x0, input int x1, input int y0, input int y1);
    res_t r;
    r.found = f;
    r.area  = 19'(area);
    r.cx    = 10'(cx);
    r.cy    = 10'(cy);
    r.xmin  = 10'(x0);
    r.xmax  = 10'(x1);
    r.ymin  = 10'(y0);
    r.ymax  = 10'(y1);
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t g, input res_t e);
    check({tag, ".found"}, 32'(g.found), 32'(e.found));
    check({tag, ".area"},  32'(g.area),  32'(e.area));
    check({tag, ".cx"},    32'(g.cx),    32'(e.cx));
    check({tag, ".cy"},    32'(g.cy),    32'(e.cy));
    check({tag, ".xmin"},  32'(g.xmin),  32'(e.xmin));
    check({tag, ".xmax"},  32'(g.xmax),  32'(e.xmax));
    check({tag, ".ymin"},  32'(g.ymin),  32'(e.ymin));
    check({tag, ".ymax"},  32'(g.ymax),  32'(e.ymax));
  endtask

  function automatic logic pix_of(input int kind, input int x, input int y);
    case (kind)
      1:       return (x == 100 && y == 50);
      2:       return (x >= 10 && x <= 19 && y >= 20 && y <= 29);
      3, 4:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Lines of `width` qualified pixels; every 7th pixel is preceded by a clken-low cycle
  // carrying a 1 that must be ignored.
  task automatic drive_frame(input int kind, input int width, input int lines);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++) begin
        if (x % 7 == 3) begin
          @(negedge clk); href = 1'b1; clken = 1'b0; pix = 1'b1;
        end
        @(negedge clk); href = 1'b1; clken = 1'b1; pix = pix_of(kind, x, y);
      end
      @(negedge clk); href = 1'b0; clken = 1'b0; pix = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Raises vsync and watches 40 cycles. With ovr_at > 0, target pixels are fed during the
  // division and a second vsync edge lands ovr_at cycles after the first.
  task automatic frame_edge(input int ovr_at, output int lat_a, output int lat_b,
                            output int nval_a, output int novr, output res_t ra, output res_t rb);
    lat_a = 0; lat_b = 0; nval_a = 0; novr = 0;
    ra = mk(1'b0, 0, 0, 0, 0, 0, 0, 0);
    rb = ra;
    @(negedge clk); vsync = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (a_valid) begin
        nval_a++;
        if (lat_a == 0) begin
          lat_a = k;
          ra = mk(a_found, int'(a_area), int'(a_cx), int'(a_cy), int'(a_xmin), int'(a_xmax),
                  int'(a_ymin), int'(a_ymax));
        end
      end
      if (b_valid && lat_b == 0) begin
        lat_b = k;
        rb = mk(b_found, int'(b_area), int'(b_cx), int'(b_cy), int'(b_xmin), int'(b_xmax),
                int'(b_ymin), int'(b_ymax));
      end
      if (a_overrun) novr++;
      if (k == 2 || k == ovr_at + 2) vsync = 1'b0;
      if (ovr_at > 0 && k >= 3 && k <= 8) begin href = 1'b1; clken = 1'b1; pix = 1'b1; end
      if (ovr_at > 0 && k == 9) begin href = 1'b0; clken = 1'b0; pix = 1'b0; end
      if (ovr_at > 0 && k == ovr_at) vsync = 1'b1;
    end
  endtask

  vec_t vecs[5];
  int   la, lb, nv, no;
  res_t ra, rb;
  res_t rect;

  initial begin
    rect    = mk(1'b1, 100, 14, 24, 10, 19, 20, 29);
    vecs[0] = '{kind: 0, width: 20,  lines: 4,  exp_a: mk(1'b0, 0, 0, 0, 0, 0, 0, 0),
                exp_b: mk(1'b0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{kind: 1, width: 110, lines: 52, exp_a: mk(1'b0, 1, 0, 0, 0, 0, 0, 0),
                exp_b: mk(1'b1, 1, 100, 50, 100, 100, 50, 50)};
    vecs[2] = '{kind: 2, width: 24,  lines: 32, exp_a: rect, exp_b: rect};
    vecs[3] = '{kind: 3, width: 128, lines: 64, exp_a: mk(1'b1, 8192, 63, 31, 0, 127, 0, 63),
                exp_b: mk(1'b1, 8192, 63, 31, 0, 127, 0, 63)};
    vecs[4] = '{kind: 4, width: 140, lines: 1,  exp_a: mk(1'b1, 140, 69, 0, 0, 139, 0, 0),
                exp_b: mk(1'b1, 140, 68, 0, 0, 127, 0, 0)};

    repeat (3) @(negedge clk);
    check("rst.valid", 32'(a_valid), 0);
    check("rst.found", 32'(a_found), 0);
    check("rst.area", 32'(a_area), 0);
    check("rst.overrun", 32'(a_overrun), 0);
    rst_n = 1'b1;

    // First edge after reset only arms accumulation.
    frame_edge(0, la, lb, nv, no, ra, rb);
    check("idle.nvalid_a", 32'(nv), 0);
    check("idle.lat_b", 32'(lb), 0);

    foreach (vecs[i]) begin
      drive_frame(vecs[i].kind, vecs[i].width, vecs[i].lines);
      frame_edge(0, la, lb, nv, no, ra, rb);
      check($sformatf("v%0d.lat_a", i), 32'(la), 30);
      check($sformatf("v%0d.lat_b", i), 32'(lb), 30);
      check($sformatf("v%0d.nvalid_a", i), 32'(nv), 1);
      check($sformatf("v%0d.overrun", i), 32'(no), 0);
      check_res($sformatf("v%0d.a", i), ra, vecs[i].exp_a);
      check_res($sformatf("v%0d.b", i), rb, vecs[i].exp_b);
    end

    repeat (20) @(negedge clk);
    check("hold.area", 32'(a_area), 140);
    check("hold.xmax", 32'(a_xmax), 139);

    // Second frame edge 10 cycles into the division.
    drive_frame(2, 24, 32);
    frame_edge(10, la, lb, nv, no, ra, rb);
    check("ovr.lat_a", 32'(la), 30);
    check("ovr.count", 32'(no), 1);
    check_res("ovr.a", ra, rect);
    drive_frame(1, 110, 52);
    frame_edge(0, la, lb, nv, no, ra, rb);
    check("post_ovr.lat_b", 32'(lb), 30);
    check("post_ovr.overrun", 32'(no), 0);
    check_res("post_ovr.b", rb, vecs[1].exp_b);
    check_res("post_ovr.a", ra, vecs[1].exp_a);

    // Reset in the middle of a line.
    drive_frame(2, 24, 25);
    repeat (5) begin
      @(negedge clk); href = 1'b1; clken = 1'b1; pix = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    href = 1'b0; clken = 1'b0; pix = 1'b0;
    check("midrst.b_cx", 32'(b_cx), 0);
    check("midrst.b_area", 32'(b_area), 0);
    check("midrst.b_found", 32'(b_found), 0);
    check("midrst.a_area", 32'(a_area), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_edge(0, la, lb, nv, no, ra, rb);
    check("midrst.first_edge_nvalid", 32'(nv), 0);
    check("midrst.first_edge_lat_b", 32'(lb), 0);
    drive_frame(2, 24, 32);
    frame_edge(0, la, lb, nv, no, ra, rb);
    check("midrst.lat_a", 32'(la), 30);
    check_res("midrst.a", ra, rect);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
